wt_sep_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD digit separator using iterative shift-and-add-3 (double dabble), one input bit per clock.
- Generalises the two-digit 0..99 separator to W-bit inputs and DIGITS decimal digits.
- Adds a start/busy/done handshake and an overflow flag.
- Sits between the time/alarm counters and the 7-segment digit drivers.

---
 rtl/wt_sep_seq.sv | 178 +++++++++++++++++
 tb/tb_wt_sep_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_sep_seq.sv
// wt_sep_seq: sequential binary-to-BCD digit separator (double dabble,
// one input bit per clock) with start/busy/done handshake and overflow flag.
// Sits between the time/alarm counters and the 7-segment digit drivers.
// Optional build macro WT_SEP_ZERO_BLANK_EN: leading zero digits are
// replaced by the blank code 4'hF at completion (digit 0 never blanked).
module wt_sep_seq #(
  parameter int unsigned W      = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          number,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);
  // 10^DIGITS < 16^DIGITS, so W + BW bits hold both the input and the limit
  localparam int unsigned LW = W + BW;

  // 10^n evaluated at elaboration time
  function automatic logic [LW-1:0] pow10(input int unsigned n);
    logic [LW-1:0] p;
    p = LW'(1);
    for (int unsigned i = 0; i < n; i++) begin
      p = p * LW'(10);
    end
    return p;
  endfunction

  localparam logic [LW-1:0] LIMIT = pow10(DIGITS);

  // Add 3 to every nibble that is 5 or more (pre-shift correction)
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

`ifdef WT_SEP_ZERO_BLANK_EN
  // Replace leading zero digits (MSD downward, excluding digit 0) with 4'hF
  function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    logic          lead;
    r    = a;
    lead = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (lead && (a[4*k +: 4] == 4'd0)) begin
        r[4*k +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            load;
  logic            shift;
  logic            last;

  logic [W-1:0]    bin_q;
  logic [BW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_pend;

  logic [BW-1:0]   acc_add;
  logic [BW-1:0]   acc_shift;
  logic [W-1:0]    bin_shift;
  logic [BW-1:0]   result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        shift = 1'b1;
        if (cnt_q == CW'(1)) begin
          last       = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        if (start) begin
          load       = 1'b1;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step; carry out of the top digit only occurs on overflow
  always_comb begin
    acc_add   = add3(acc_q);
    acc_shift = BW'({acc_add, bin_q[W-1]});
    bin_shift = bin_q << 1;
`ifdef WT_SEP_ZERO_BLANK_EN
    result    = blank_lead(ovf_pend ? '0 : acc_shift);
`else
    result    = ovf_pend ? '0 : acc_shift;
`endif
  end

  // Shift/accumulate registers and latched overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_pend <= 1'b0;
    end else if (load) begin
      bin_q    <= number;
      acc_q    <= '0;
      cnt_q    <= CW'(W);
      ovf_pend <= (LW'(number) >= LIMIT);
    end else if (shift) begin
      bin_q    <= bin_shift;
      acc_q    <= acc_shift;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // Registered handshake and result outputs; result held until next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
      bcd  <= '0;
    end else begin
      busy <= (state_next == CONV);
      done <= (state_next == FIN);
      if (last) begin
        bcd <= result;
        ovf <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_wt_sep_seq.sv
// Scoreboard bench for wt_sep_seq at three parameter sets:
// dut 0 (W=7,DIGITS=2), dut 1 (W=10,DIGITS=3), dut 2 (W=1,DIGITS=1).
module tb_wt_sep_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [6:0]  nm0 = '0;
  logic [9:0]  nm1 = '0;
  logic [0:0]  nm2 = '0;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        ovf0, ovf1, ovf2;
  logic [7:0]  bcd0;
  logic [11:0] bcd1;
  logic [3:0]  bcd2;

  wt_sep_seq #(.W(7), .DIGITS(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .number(nm0),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0));
  wt_sep_seq #(.W(10), .DIGITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .number(nm1),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1));
  wt_sep_seq #(.W(1), .DIGITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .number(nm2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2));

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          due;
    int          num;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int wv(input int d);
    return (d == 0) ? 7 : (d == 1) ? 10 : 1;
  endfunction

  function automatic int dv(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  // Leading-zero blanking of a hand-written expected value (identity by default)
  function automatic logic [11:0] bl(input logic [11:0] v, input int digits);
    logic [11:0] r;
    r = v;
`ifdef WT_SEP_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = digits - 1; k >= 1; k--) begin
        if (lead && (r[4*k +: 4] == 4'd0)) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  // Decimal reference using division
  function automatic logic [11:0] model_bcd(input int n, input int digits);
    logic [11:0] r;
    int lim;
    int v;
    r   = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (n < lim) begin
      v = n;
      for (int k = 0; k < digits; k++) begin
        r[4*k +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return bl(r, digits);
  endfunction

  function automatic logic model_ovf(input int n, input int digits);
    int lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return n >= lim;
  endfunction

  task automatic push(input int d, input int n, input logic [11:0] b, input logic o, input int due);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    e.due = due;
    e.num = n;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called just after a rising edge with the DUT idle; pulses start for one edge
  task automatic issue(input int d, input int n, input logic [11:0] b, input logic o);
    push(d, n, b, o, cyc + 1 + wv(d));
    case (d)
      0: begin st0 = 1'b1; nm0 = 7'(n); end
      1: begin st1 = 1'b1; nm1 = 10'(n); end
      default: begin st2 = 1'b1; nm2 = 1'(n); end
    endcase
    @(posedge clk);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
    case (d)
      0: check("busy0_after_start", 32'(busy0), 32'd1);
      1: check("busy1_after_start", 32'(busy1), 32'd1);
      default: check("busy2_after_start", 32'(busy2), 32'd1);
    endcase
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  // Bounded wait for all expected results of one DUT
  task automatic wait_idle(input int d);
    for (int i = 0; i < 60; i++) begin
      if (qsize(d) == 0) break;
      @(negedge clk);
      #1;
    end
    if (qsize(d) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_dut%0d: got %0d pending results expected 0", d, qsize(d));
      case (d)
        0: q0.delete();
        1: q1.delete();
        default: q2.delete();
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input int d, input logic [11:0] b, input logic o);
    exp_t e;
    if (qsize(d) == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_done_dut%0d: got done=1 expected no done (cyc=%0d)", d, cyc);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("bcd_dut%0d_n%0d", d, e.num), 32'(b), 32'(e.bcd));
      check($sformatf("ovf_dut%0d_n%0d", d, e.num), 32'(o), 32'(e.ovf));
      check($sformatf("done_cycle_dut%0d_n%0d", d, e.num), 32'(cyc), 32'(e.due));
    end
  endtask

  // Monitors: compare whenever a DUT presents done
  always @(negedge clk) if (done0) compare(0, 12'(bcd0), ovf0);
  always @(negedge clk) if (done1) compare(1, bcd1, ovf1);
  always @(negedge clk) if (done2) compare(2, 12'(bcd2), ovf2);

  initial begin
    int c;
    #3;
    check("reset_busy0", 32'(busy0), 32'd0);
    check("reset_done0", 32'(done0), 32'd0);
    check("reset_ovf0", 32'(ovf0), 32'd0);
    check("reset_bcd0", 32'(bcd0), 32'd0);
    check("reset_bcd1", 32'(bcd1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, W=7 DIGITS=2
    issue(0, 57, bl(12'h057, 2), 1'b0);  wait_idle(0);
    issue(0, 9, bl(12'h009, 2), 1'b0);   wait_idle(0);
    issue(0, 0, bl(12'h000, 2), 1'b0);   wait_idle(0);
    issue(0, 99, bl(12'h099, 2), 1'b0);  wait_idle(0);
    issue(0, 100, bl(12'h000, 2), 1'b1); wait_idle(0);
    issue(0, 127, bl(12'h000, 2), 1'b1); wait_idle(0);

    // Directed values, W=10 DIGITS=3
    issue(1, 999, bl(12'h999, 3), 1'b0);  wait_idle(1);
    issue(1, 1000, bl(12'h000, 3), 1'b1); wait_idle(1);
    issue(1, 1023, bl(12'h000, 3), 1'b1); wait_idle(1);
    issue(1, 5, bl(12'h005, 3), 1'b0);    wait_idle(1);
    issue(1, 470, bl(12'h470, 3), 1'b0);  wait_idle(1);

    // Directed values, W=1 DIGITS=1
    issue(2, 1, 12'h001, 1'b0); wait_idle(2);
    issue(2, 0, 12'h000, 1'b0); wait_idle(2);

    // Full sweep of the 7-bit input range
    for (int n = 0; n < 128; n++) begin
      issue(0, n, model_bcd(n, 2), model_ovf(n, 2));
      wait_idle(0);
    end

    // START during conversion is ignored
    issue(0, 34, bl(12'h034, 2), 1'b0);
    @(posedge clk);
    #1;
    st0 = 1'b1;
    nm0 = 7'd12;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    wait_idle(0);

    // START held through FIN: back-to-back conversion W+1 cycles later
    c = cyc;
    push(0, 34, bl(12'h034, 2), 1'b0, c + 8);
    push(0, 45, bl(12'h045, 2), 1'b0, c + 16);
    st0 = 1'b1;
    nm0 = 7'd34;
    @(posedge clk);
    #1;
    nm0 = 7'd45;
    repeat (8) @(posedge clk);
    #1;
    st0 = 1'b0;
    wait_idle(0);

    // Asynchronous reset mid-conversion discards the partial result
    issue(0, 77, bl(12'h077, 2), 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy0", 32'(busy0), 32'd0);
    check("midreset_done0", 32'(done0), 32'd0);
    check("midreset_ovf0", 32'(ovf0), 32'd0);
    check("midreset_bcd0", 32'(bcd0), 32'd0);
    q0.delete();
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_busy0", 32'(busy0), 32'd0);
    check("post_reset_bcd0", 32'(bcd0), 32'd0);

    // Conversion still works after reset
    issue(0, 63, bl(12'h063, 2), 1'b0);
    wait_idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
